// File: rtl/pc_sequencer_if.sv
// Bus between the next-PC sequencer and the core: PC feedback, redirect requests and sequencer status.
interface pc_sequencer_if;
   localparam int unsigned XLEN = 32;

   logic [XLEN-1:0] PC;
   logic [XLEN-1:0] PC_Next;
   logic            imem_ready;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            jump;
   logic [XLEN-1:0] jump_target;
   logic            trap_req;
   logic            mret;
   logic            halt;
   logic            resume;
   logic            fetch_valid;
   logic [XLEN-1:0] epc;
   logic [1:0]      trap_cause;
   logic [2:0]      state;

   // Sequencer side
   modport master (
      input  PC, imem_ready, branch_taken, branch_target, jump, jump_target,
             trap_req, mret, halt, resume,
      output PC_Next, fetch_valid, epc, trap_cause, state
   );

   // Core / PC register side
   modport slave (
      output PC, imem_ready, branch_taken, branch_target, jump, jump_target,
             trap_req, mret, halt, resume,
      input  PC_Next, fetch_valid, epc, trap_cause, state
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller for the single-cycle RV32I core: boot, sequential fetch, redirects,
// trap entry/return, halt and instruction-memory wait.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned BOOT_CYCLES  = 2
) (
   input  logic           clk,
   input  logic           rst,
   pc_sequencer_if.master bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_TRAP     = 2'b01;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

   typedef enum logic [2:0] {
      ST_BOOT = 3'b000,
      ST_RUN  = 3'b001,
      ST_WAIT = 3'b010,
      ST_TRAP = 3'b011,
      ST_HALT = 3'b100
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
   logic [XLEN-1:0]  epc_q, epc_d;
   logic [1:0]       cause_q, cause_d;
   logic [XLEN-1:0]  pc_next_c;
   logic             fetch_valid_c;
   logic [XLEN-1:0]  pc_plus4;
   logic [XLEN-1:0]  target;

   assign pc_plus4 = bus.PC + XLEN'(4);

   // Next-state, next-PC and trap bookkeeping
   always_comb begin
      state_d       = state_q;
      boot_cnt_d    = boot_cnt_q;
      epc_d         = epc_q;
      cause_d       = cause_q;
      pc_next_c     = bus.PC;
      fetch_valid_c = 1'b0;
      target        = bus.jump ? bus.jump_target : bus.branch_target;

      case (state_q)
         ST_BOOT: begin
            pc_next_c  = RESET_VECTOR;
            boot_cnt_d = boot_cnt_q + CNT_W'(1);
            if (boot_cnt_q >= BOOT_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            fetch_valid_c = bus.imem_ready;
            if (!bus.imem_ready) begin
               state_d = ST_WAIT;
            end else if (bus.trap_req) begin
               epc_d   = bus.PC;
               cause_d = CAUSE_TRAP;
               state_d = ST_TRAP;
            end else if (bus.halt) begin
               state_d = ST_HALT;
            end else if (bus.mret) begin
               pc_next_c = epc_q + XLEN'(4);
            end else if (bus.jump || bus.branch_taken) begin
               // A misaligned target is never fetched; it traps at the redirecting PC
               if (target[1:0] != 2'b00) begin
                  epc_d   = bus.PC;
                  cause_d = CAUSE_MISALIGN;
                  state_d = ST_TRAP;
               end else begin
                  pc_next_c = target;
               end
            end else begin
               pc_next_c = pc_plus4;
            end
         end
         ST_WAIT: begin
            if (bus.imem_ready) begin
               state_d = ST_RUN;
            end
         end
         ST_TRAP: begin
            pc_next_c = TRAP_VECTOR;
            state_d   = ST_RUN;
         end
         ST_HALT: begin
            if (bus.resume) begin
               pc_next_c = pc_plus4;
               state_d   = ST_RUN;
            end
         end
         default: begin
            pc_next_c = RESET_VECTOR;
            state_d   = ST_BOOT;
         end
      endcase

      // Reset is visible on PC_Next in the same cycle it is asserted
      if (!rst) begin
         pc_next_c     = RESET_VECTOR;
         fetch_valid_c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= '0;
         epc_q      <= '0;
         cause_q    <= CAUSE_NONE;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         epc_q      <= epc_d;
         cause_q    <= cause_d;
      end
   end

   assign bus.PC_Next     = pc_next_c;
   assign bus.fetch_valid = fetch_valid_c;
   assign bus.epc         = epc_q;
   assign bus.trap_cause  = cause_q;
   assign bus.state       = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a PC_Module model closing the PC_Next -> PC loop.
module tb_pc_sequencer;
   localparam logic [2:0] S_BOOT = 3'b000;
   localparam logic [2:0] S_RUN  = 3'b001;
   localparam logic [2:0] S_WAIT = 3'b010;
   localparam logic [2:0] S_TRAP = 3'b011;
   localparam logic [2:0] S_HALT = 3'b100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_load = 1'b0;
   logic [31:0] pc_load_val = '0;
   logic [31:0] pc_q;
   int          errors = 0;
   int          checks = 0;

   pc_sequencer_if bus ();

   pc_sequencer #(
      .RESET_VECTOR(32'h0000_0000),
      .TRAP_VECTOR (32'h0000_0100),
      .BOOT_CYCLES (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // PC_Module model, with a load port to place PC anywhere
   always @(posedge clk) pc_q <= pc_load ? pc_load_val : bus.PC_Next;
   assign bus.PC = pc_q;

   task automatic idle();
      bus.imem_ready    = 1'b1;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.jump          = 1'b0;
      bus.jump_target   = '0;
      bus.trap_req      = 1'b0;
      bus.mret          = 1'b0;
      bus.halt          = 1'b0;
      bus.resume        = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_pc(input logic [31:0] v);
      pc_load = 1'b1;
      pc_load_val = v;
      step();
      pc_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      step();
      #1;
      checks++; if (bus.PC_Next !== 32'h0) begin errors++; $display("FAIL rst_pcnext: got %h want %h", bus.PC_Next, 32'h0); end
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fv: got %b want 0", bus.fetch_valid); end
      checks++; if (bus.state !== S_BOOT) begin errors++; $display("FAIL rst_state: got %b want %b", bus.state, S_BOOT); end
      checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL rst_epc: got %h want 0", bus.epc); end
      checks++; if (bus.trap_cause !== 2'b00) begin errors++; $display("FAIL rst_cause: got %b want 00", bus.trap_cause); end
      step();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (bus.state !== S_BOOT) begin errors++; $display("FAIL boot_state[%0d]: got %b want %b", i, bus.state, S_BOOT); end
         checks++; if (bus.PC_Next !== 32'h0) begin errors++; $display("FAIL boot_pcnext[%0d]: got %h want 0", i, bus.PC_Next); end
         checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_fv[%0d]: got %b want 0", i, bus.fetch_valid); end
         step();
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bus.state !== S_RUN) begin errors++; $display("FAIL seq_state[%0d]: got %b want %b", i, bus.state, S_RUN); end
         checks++; if (bus.PC !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.PC, 32'(4 * i)); end
         checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fv[%0d]: got %b want 1", i, bus.fetch_valid); end
         step();
      end
   endtask

   task automatic test_redirects();
      set_pc(32'h10);
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h40;
      #1;
      checks++; if (bus.PC_Next !== 32'h40) begin errors++; $display("FAIL br_pcnext: got %h want %h", bus.PC_Next, 32'h40); end
      step();
      idle();
      #1;
      checks++; if (bus.PC !== 32'h40) begin errors++; $display("FAIL br_pc: got %h want %h", bus.PC, 32'h40); end
      bus.jump = 1'b1;
      bus.jump_target = 32'h80;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h60;
      #1;
      checks++; if (bus.PC_Next !== 32'h80) begin errors++; $display("FAIL jmp_pri_pcnext: got %h want %h", bus.PC_Next, 32'h80); end
      step();
      idle();
      #1;
      checks++; if (bus.PC !== 32'h80) begin errors++; $display("FAIL jmp_pc: got %h want %h", bus.PC, 32'h80); end
      bus.jump = 1'b1;
      bus.jump_target = 32'h82;
      #1;
      checks++; if (bus.PC_Next !== 32'h80) begin errors++; $display("FAIL mis_pcnext: got %h want %h", bus.PC_Next, 32'h80); end
      step();
      idle();
      #1;
      checks++; if (bus.state !== S_TRAP) begin errors++; $display("FAIL mis_state: got %b want %b", bus.state, S_TRAP); end
      checks++; if (bus.epc !== 32'h80) begin errors++; $display("FAIL mis_epc: got %h want %h", bus.epc, 32'h80); end
      checks++; if (bus.trap_cause !== 2'b10) begin errors++; $display("FAIL mis_cause: got %b want 10", bus.trap_cause); end
      checks++; if (bus.PC_Next !== 32'h100) begin errors++; $display("FAIL mis_vec: got %h want %h", bus.PC_Next, 32'h100); end
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL mis_fv: got %b want 0", bus.fetch_valid); end
      step();
      #1;
      checks++; if (bus.PC !== 32'h100) begin errors++; $display("FAIL mis_handler_pc: got %h want %h", bus.PC, 32'h100); end
      checks++; if (bus.state !== S_RUN) begin errors++; $display("FAIL mis_ret_state: got %b want %b", bus.state, S_RUN); end
   endtask

   task automatic test_trap_mret();
      set_pc(32'h24);
      bus.trap_req = 1'b1;
      bus.jump = 1'b1;
      bus.jump_target = 32'h200;
      #1;
      checks++; if (bus.PC_Next !== 32'h24) begin errors++; $display("FAIL trap_pcnext: got %h want %h", bus.PC_Next, 32'h24); end
      step();
      idle();
      #1;
      checks++; if (bus.state !== S_TRAP) begin errors++; $display("FAIL trap_state: got %b want %b", bus.state, S_TRAP); end
      checks++; if (bus.epc !== 32'h24) begin errors++; $display("FAIL trap_epc: got %h want %h", bus.epc, 32'h24); end
      checks++; if (bus.trap_cause !== 2'b01) begin errors++; $display("FAIL trap_cause: got %b want 01", bus.trap_cause); end
      step();
      #1;
      checks++; if (bus.PC !== 32'h100) begin errors++; $display("FAIL trap_handler_pc: got %h want %h", bus.PC, 32'h100); end
      step();
      bus.mret = 1'b1;
      bus.jump = 1'b1;
      bus.jump_target = 32'h300;
      #1;
      checks++; if (bus.PC_Next !== 32'h28) begin errors++; $display("FAIL mret_pcnext: got %h want %h", bus.PC_Next, 32'h28); end
      step();
      idle();
      #1;
      checks++; if (bus.PC !== 32'h28) begin errors++; $display("FAIL mret_pc: got %h want %h", bus.PC, 32'h28); end
   endtask

   task automatic test_imem_wait();
      set_pc(32'h30);
      for (int i = 0; i < 3; i++) begin
         bus.imem_ready = 1'b0;
         bus.branch_taken = (i == 1);
         bus.branch_target = 32'h40;
         #1;
         checks++; if (bus.state !== ((i == 0) ? S_RUN : S_WAIT)) begin errors++; $display("FAIL wait_state[%0d]: got %b", i, bus.state); end
         checks++; if (bus.PC !== 32'h30) begin errors++; $display("FAIL wait_pc[%0d]: got %h want %h", i, bus.PC, 32'h30); end
         checks++; if (bus.PC_Next !== 32'h30) begin errors++; $display("FAIL wait_pcnext[%0d]: got %h want %h", i, bus.PC_Next, 32'h30); end
         checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL wait_fv[%0d]: got %b want 0", i, bus.fetch_valid); end
         step();
      end
      idle();
      #1;
      checks++; if (bus.state !== S_WAIT) begin errors++; $display("FAIL wait_exit_state: got %b want %b", bus.state, S_WAIT); end
      checks++; if (bus.PC_Next !== 32'h30) begin errors++; $display("FAIL wait_exit_pcnext: got %h want %h", bus.PC_Next, 32'h30); end
      step();
      #1;
      checks++; if (bus.state !== S_RUN) begin errors++; $display("FAIL wait_run_state: got %b want %b", bus.state, S_RUN); end
      checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL wait_run_fv: got %b want 1", bus.fetch_valid); end
      checks++; if (bus.PC_Next !== 32'h34) begin errors++; $display("FAIL wait_run_pcnext: got %h want %h", bus.PC_Next, 32'h34); end
      step();
      #1;
      checks++; if (bus.PC !== 32'h34) begin errors++; $display("FAIL wait_next_pc: got %h want %h", bus.PC, 32'h34); end
   endtask

   task automatic test_halt_wrap();
      set_pc(32'h50);
      bus.halt = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h70;
      #1;
      checks++; if (bus.PC_Next !== 32'h50) begin errors++; $display("FAIL halt_pcnext: got %h want %h", bus.PC_Next, 32'h50); end
      step();
      idle();
      for (int i = 0; i < 5; i++) begin
         bus.trap_req = (i == 2);
         #1;
         checks++; if (bus.state !== S_HALT) begin errors++; $display("FAIL halt_state[%0d]: got %b want %b", i, bus.state, S_HALT); end
         checks++; if (bus.PC !== 32'h50) begin errors++; $display("FAIL halt_pc[%0d]: got %h want %h", i, bus.PC, 32'h50); end
         checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_fv[%0d]: got %b want 0", i, bus.fetch_valid); end
         step();
      end
      idle();
      bus.resume = 1'b1;
      #1;
      checks++; if (bus.PC_Next !== 32'h54) begin errors++; $display("FAIL resume_pcnext: got %h want %h", bus.PC_Next, 32'h54); end
      step();
      idle();
      #1;
      checks++; if (bus.state !== S_RUN) begin errors++; $display("FAIL resume_state: got %b want %b", bus.state, S_RUN); end
      checks++; if (bus.PC !== 32'h54) begin errors++; $display("FAIL resume_pc: got %h want %h", bus.PC, 32'h54); end
      checks++; if (bus.epc !== 32'h24) begin errors++; $display("FAIL halt_epc_kept: got %h want %h", bus.epc, 32'h24); end
      set_pc(32'hFFFF_FFFC);
      #1;
      checks++; if (bus.PC_Next !== 32'h0) begin errors++; $display("FAIL wrap_pcnext: got %h want 0", bus.PC_Next); end
      step();
      #1;
      checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", bus.PC); end
      checks++; if (bus.state !== S_RUN) begin errors++; $display("FAIL wrap_state: got %b want %b", bus.state, S_RUN); end
   endtask

   task automatic test_reset_mid_trap();
      set_pc(32'h60);
      bus.trap_req = 1'b1;
      step();
      idle();
      #1;
      checks++; if (bus.state !== S_TRAP) begin errors++; $display("FAIL mt_state: got %b want %b", bus.state, S_TRAP); end
      checks++; if (bus.epc !== 32'h60) begin errors++; $display("FAIL mt_epc: got %h want %h", bus.epc, 32'h60); end
      rst = 1'b0;
      #1;
      checks++; if (bus.PC_Next !== 32'h0) begin errors++; $display("FAIL mt_rst_pcnext: got %h want 0", bus.PC_Next); end
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL mt_rst_fv: got %b want 0", bus.fetch_valid); end
      step();
      #1;
      checks++; if (bus.state !== S_BOOT) begin errors++; $display("FAIL mt_state_boot: got %b want %b", bus.state, S_BOOT); end
      checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL mt_epc_clr: got %h want 0", bus.epc); end
      checks++; if (bus.trap_cause !== 2'b00) begin errors++; $display("FAIL mt_cause_clr: got %b want 00", bus.trap_cause); end
      checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL mt_pc: got %h want 0", bus.PC); end
      rst = 1'b1;
      step();
      step();
      #1;
      checks++; if (bus.state !== S_RUN) begin errors++; $display("FAIL mt_reboot_state: got %b want %b", bus.state, S_RUN); end
      checks++; if (bus.PC_Next !== 32'h4) begin errors++; $display("FAIL mt_reboot_pcnext: got %h want %h", bus.PC_Next, 32'h4); end
   endtask

   initial begin
      test_reset();
      test_redirects();
      test_trap_mret();
      test_imem_wait();
      test_halt_wrap();
      test_reset_mid_trap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
